// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-seven-segment table for the display scan path.
package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } disp_buf_t;

  localparam disp_buf_t DISP_DARK = '{digits: 32'h0, dp: 8'h00, blank: 8'hFF};

  // Active-low {G,F,E,D,C,B,A}
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational 4-bit hex digit to active-low seven-segment pattern.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex7(nibble);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-aligned double buffering
// of display data and registered cathode outputs aligned with the anode select.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 100_000
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic        load,
  output logic        pending,
  output logic [2:0]  rr,
  output logic [6:0]  seg,
  output logic        DP,
  output logic        frame_start
);

  localparam int              CNT_W    = $clog2(DIGIT_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [2:0]       RR_LAST  = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             boundary;
  disp_buf_t        active;
  disp_buf_t        shadow;
  disp_buf_t        load_buf;
  logic [31:0]      digits_shifted;
  logic [3:0]       cur_nibble;
  logic [2:0]       bit_idx;
  logic             cur_blank;
  logic             cur_dp;
  logic [6:0]       dec_seg;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (rr == RR_LAST);
  assign load_buf = '{digits: digits_in, dp: dp_in, blank: blank_in};

  // Digit 0 lives in the top nibble while its dp/blank flags live in bit 7.
  assign digits_shifted = active.digits << {rr, 2'b00};
  assign cur_nibble     = digits_shifted[31:28];
  assign bit_idx        = RR_LAST - rr;
  assign cur_blank      = active.blank[bit_idx];
  assign cur_dp         = active.dp[bit_idx];

  hex7seg_dec u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cnt         <= '0;
      rr          <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + CNT_W'(1);
      rr          <= tick ? rr + 3'd1 : rr;
      frame_start <= boundary;
    end
  end

  // A load coinciding with the boundary bypasses the shadow so it is never lost or delayed a frame.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      active  <= DISP_DARK;
      shadow  <= DISP_DARK;
      pending <= 1'b0;
    end else if (load) begin
      shadow <= load_buf;
      if (boundary) begin
        active  <= load_buf;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      seg <= SEG_BLANK;
      DP  <= 1'b1;
    end else if (cur_blank) begin
      seg <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      seg <= dec_seg;
      DP  <= ~cur_dp;
    end
  end

endmodule
